// File: rtl/writeback_buffer_if.sv
// Cache-side and memory-side signals of the writeback buffer.
// The buffer connects through the slave modport; the cache/memory side uses master.
interface writeback_buffer_if #(
    parameter int LA_W  = 26,
    parameter int CNT_W = 3
);
    logic             wb_valid;
    logic [LA_W-1:0]  wb_addr;
    logic             wb_ready;
    logic             lk_valid;
    logic [LA_W-1:0]  lk_addr;
    logic             lk_hit;
    logic             mem_valid;
    logic [LA_W-1:0]  mem_addr;
    logic             mem_ready;
    logic [CNT_W-1:0] count;
    logic [31:0]      num_writebacks;
    logic [31:0]      num_reclaims;
    logic [31:0]      num_coalesced;

    // valid/ready: a transfer happens on a rising edge where both are high;
    // the offering side holds valid and its payload stable until that edge.
    modport master (
        output wb_valid, wb_addr, lk_valid, lk_addr, mem_ready,
        input  wb_ready, lk_hit, mem_valid, mem_addr, count,
               num_writebacks, num_reclaims, num_coalesced
    );

    modport slave (
        input  wb_valid, wb_addr, lk_valid, lk_addr, mem_ready,
        output wb_ready, lk_hit, mem_valid, mem_addr, count,
               num_writebacks, num_reclaims, num_coalesced
    );
endinterface

// File: rtl/writeback_buffer.sv
// Age-ordered dirty-line writeback buffer: drains slot 0 to memory, coalesces
// repeated evictions and lets cache misses reclaim pending lines.
module writeback_buffer #(
    parameter int DEPTH     = 4,
    parameter int line_size = 64,
    localparam int LA_W     = 32 - $clog2(line_size),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    writeback_buffer_if.slave bus
);
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [LA_W-1:0]  addr_q [DEPTH];
    logic [LA_W-1:0]  addr_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      num_writebacks_q, num_writebacks_d;
    logic [31:0]      num_reclaims_q, num_reclaims_d;
    logic [31:0]      num_coalesced_q, num_coalesced_d;

    logic             wb_ready;
    logic             push, drain, collide, reclaim_k, coalesce, alloc;
    logic [DEPTH-1:0] lk_match, wb_match, keep;
    logic [CNT_W-1:0] rank [DEPTH];
    logic [CNT_W-1:0] kept;

    assign wb_ready = (count_q < CNT_W'(DEPTH));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            lk_match[i] = valid_q[i] && (addr_q[i] == bus.lk_addr);
            wb_match[i] = valid_q[i] && (addr_q[i] == bus.wb_addr);
        end
        push    = bus.wb_valid && wb_ready;
        drain   = valid_q[0] && bus.mem_ready;
        // A push colliding with a same-cycle miss is handed straight back to the cache.
        collide = push && bus.lk_valid && (bus.wb_addr == bus.lk_addr);
        // Slot 0 is never reclaimed so the address offered to memory stays stable.
        reclaim_k = bus.lk_valid && (|lk_match[DEPTH-1:1]);
        coalesce  = push && !collide && (|wb_match);
        alloc     = push && !collide && !(|wb_match);
        for (int i = 0; i < DEPTH; i++) begin
            keep[i] = valid_q[i]
                      && !((i != 0) && bus.lk_valid && lk_match[i])
                      && !((i == 0) && drain);
        end
    end

    // Compact surviving entries toward slot 0, then append any new allocation.
    always_comb begin
        rank[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            rank[i] = rank[i-1] + CNT_W'(keep[i-1]);
        end
        kept = rank[DEPTH-1] + CNT_W'(keep[DEPTH-1]);

        valid_d = '0;
        for (int o = 0; o < DEPTH; o++) begin
            addr_d[o] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (keep[i] && (rank[i] == CNT_W'(o))) begin
                    valid_d[o] = 1'b1;
                    addr_d[o]  = addr_q[i];
                end
            end
            if (alloc && (kept == CNT_W'(o))) begin
                valid_d[o] = 1'b1;
                addr_d[o]  = bus.wb_addr;
            end
        end
        count_d = kept + CNT_W'(alloc);

        num_writebacks_d = num_writebacks_q + 32'(drain);
        num_reclaims_d   = num_reclaims_q + 32'(reclaim_k || collide);
        num_coalesced_d  = num_coalesced_q + 32'(coalesce);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q          <= '0;
            count_q          <= '0;
            num_writebacks_q <= '0;
            num_reclaims_q   <= '0;
            num_coalesced_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q          <= valid_d;
            count_q          <= count_d;
            num_writebacks_q <= num_writebacks_d;
            num_reclaims_q   <= num_reclaims_d;
            num_coalesced_q  <= num_coalesced_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    assign bus.wb_ready       = wb_ready;
    assign bus.lk_hit         = bus.lk_valid && ((|lk_match) || collide);
    assign bus.mem_valid      = valid_q[0];
    assign bus.mem_addr       = addr_q[0];
    assign bus.count          = count_q;
    assign bus.num_writebacks = num_writebacks_q;
    assign bus.num_reclaims   = num_reclaims_q;
    assign bus.num_coalesced  = num_coalesced_q;
endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: fill/drain, reclaim, coalesce,
// simultaneous events and asynchronous reset.
module tb_writeback_buffer;
    localparam int LA_W  = 26;
    localparam int CNT_W = 3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    writeback_buffer_if #(.LA_W(LA_W), .CNT_W(CNT_W)) bus ();

    writeback_buffer #(.DEPTH(4), .line_size(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [LA_W-1:0] a);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.lk_valid  = 1'b0;
        bus.lk_addr   = '0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        idle_inputs();

        // Reset values; lookup of address 0 must miss on empty slots.
        #2 rst_n = 1'b0;
        tick();
        bus.lk_valid = 1'b1;
        bus.lk_addr  = '0;
        #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wb_ready", 32'(bus.wb_ready), 32'd1);
        chk("rst_lk_hit", 32'(bus.lk_hit), 32'd0);
        chk("rst_wbacks", bus.num_writebacks, 32'd0);
        chk("rst_reclaims", bus.num_reclaims, 32'd0);
        chk("rst_coalesced", bus.num_coalesced, 32'd0);
        bus.lk_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Fill with memory stalled; fifth push is refused.
        push(26'h100);
        chk("fill_first_offer", 32'(bus.mem_valid), 32'd1);
        push(26'h101);
        push(26'h102);
        push(26'h103);
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_wb_ready", 32'(bus.wb_ready), 32'd0);
        chk("fill_mem_addr", 32'(bus.mem_addr), 32'h100);
        push(26'h104);
        chk("full_push_count", 32'(bus.count), 32'd4);
        chk("full_mem_addr_stable", 32'(bus.mem_addr), 32'h100);
        chk("full_coalesced", bus.num_coalesced, 32'd0);

        // Ordered back-to-back drain.
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(bus.mem_valid), 32'd1);
            chk("drain_addr", 32'(bus.mem_addr), 32'h100 + 32'(i));
            tick();
        end
        chk("drain_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("drain_count", 32'(bus.count), 32'd0);
        chk("drain_wbacks", bus.num_writebacks, 32'd4);
        bus.mem_ready = 1'b0;

        // Reclaim of a younger slot, then a lookup hit on slot 0 that stays.
        push(26'h10);
        push(26'h20);
        push(26'h30);
        chk("rc_count3", 32'(bus.count), 32'd3);
        bus.lk_valid = 1'b1;
        bus.lk_addr  = 26'h20;
        #1;
        chk("rc_hit20", 32'(bus.lk_hit), 32'd1);
        tick();
        chk("rc_count2", 32'(bus.count), 32'd2);
        chk("rc_gone20", 32'(bus.lk_hit), 32'd0);
        chk("rc_reclaims1", bus.num_reclaims, 32'd1);
        bus.lk_addr = 26'h10;
        #1;
        chk("rc_hit10", 32'(bus.lk_hit), 32'd1);
        tick();
        chk("rc_slot0_count", 32'(bus.count), 32'd2);
        chk("rc_slot0_reclaims", bus.num_reclaims, 32'd1);
        bus.lk_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        chk("rc_order0", 32'(bus.mem_addr), 32'h10);
        tick();
        chk("rc_order1", 32'(bus.mem_addr), 32'h30);
        tick();
        chk("rc_empty", 32'(bus.count), 32'd0);
        chk("rc_wbacks", bus.num_writebacks, 32'd6);
        bus.mem_ready = 1'b0;

        // Coalesce a repeated eviction; unrelated lookup misses.
        push(26'h55);
        push(26'h55);
        chk("co_count", 32'(bus.count), 32'd1);
        chk("co_coalesced", bus.num_coalesced, 32'd1);
        bus.lk_valid = 1'b1;
        bus.lk_addr  = 26'h56;
        #1;
        chk("co_lk_miss", 32'(bus.lk_hit), 32'd0);
        bus.lk_valid = 1'b0;

        // Drain + reclaim + push in the same cycle, from a fresh reset.
        do_reset();
        push(26'hA);
        push(26'hB);
        push(26'hC);
        bus.mem_ready = 1'b1;
        bus.lk_valid  = 1'b1;
        bus.lk_addr   = 26'hC;
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 26'hD;
        #1;
        chk("sim_lk_hit", 32'(bus.lk_hit), 32'd1);
        tick();
        idle_inputs();
        #1;
        chk("sim_count", 32'(bus.count), 32'd2);
        chk("sim_head", 32'(bus.mem_addr), 32'hB);
        chk("sim_wbacks", bus.num_writebacks, 32'd1);
        chk("sim_reclaims", bus.num_reclaims, 32'd1);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("sim_second", 32'(bus.mem_addr), 32'hD);

        // Push colliding with a lookup of the same absent line is not stored.
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 26'hE;
        bus.lk_valid = 1'b1;
        bus.lk_addr  = 26'hE;
        #1;
        chk("col_lk_hit", 32'(bus.lk_hit), 32'd1);
        tick();
        idle_inputs();
        chk("col_count", 32'(bus.count), 32'd1);
        chk("col_reclaims", bus.num_reclaims, 32'd2);
        chk("col_coalesced", bus.num_coalesced, 32'd0);

        // Asynchronous reset mid-operation with three entries.
        push(26'hF);
        push(26'h11);
        chk("mr_count", 32'(bus.count), 32'd3);
        chk("mr_valid", 32'(bus.mem_valid), 32'd1);
        bus.mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("mr_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("mr_count0", 32'(bus.count), 32'd0);
        chk("mr_wbacks", bus.num_writebacks, 32'd0);
        chk("mr_reclaims", bus.num_reclaims, 32'd0);
        chk("mr_wb_ready", 32'(bus.wb_ready), 32'd1);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_buffer.md
# writeback_buffer

Dirty-line writeback buffer that sits directly downstream of the cache. It accepts line addresses of dirty victims evicted by the cache and holds them in age order. It drains them one at a time to the memory interface over a valid/ready handshake. Cache misses look up the buffer so that a line still pending writeback is reclaimed instead of being refetched.

## Interface
- `DEPTH`, 4: number of buffer entries (2 to 16).
- `line_size`, 64: cache line size in bytes (32 to 128, power of two).
- `LA_W`, derived as 32 − $clog2(line_size): line-address width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wb_valid` in 1: cache presents a dirty eviction.
- `wb_addr` in LA_W: line address of the eviction.
- `wb_ready` out 1: buffer can accept; equals (count < DEPTH).
- `lk_valid` in 1: cache presents a miss lookup.
- `lk_addr` in LA_W: line address of the miss.
- `lk_hit` out 1: combinational; a valid entry matches `lk_addr`.
- `mem_valid` out 1: a writeback is offered to memory.
- `mem_addr` out LA_W: line address of the offered writeback.
- `mem_ready` in 1: memory accepts the offered writeback.
- `count` out $clog2(DEPTH+1): number of occupied entries.
- `num_writebacks` out 32: completed memory handshakes.
- `num_reclaims` out 32: entries removed by lookup.
- `num_coalesced` out 32: pushes merged into an existing entry.

## Operation
- Storage: slots 0..DEPTH−1, kept in age order with slot 0 oldest. Each slot holds a valid bit and a line address. Occupied slots are always contiguous from slot 0.
- Drain: `mem_valid` = slot 0 valid; `mem_addr` = slot 0 address. A handshake (`mem_valid & mem_ready`) removes slot 0, and the remaining slots shift down by one.
- Push: `wb_valid & wb_ready`.
  - If `wb_addr` matches a valid slot, no new entry is allocated and `num_coalesced` increments.
  - Otherwise the address is written to the first free slot, after accounting for any same-cycle removal.
  - `wb_valid & !wb_ready` is ignored. The cache holds its request.
- Lookup: `lk_hit` = `lk_valid` and any valid slot address equals `lk_addr`.
  - A matching slot k>0 is removed at the edge, slots above it compact down, and `num_reclaims` increments.
  - A matching slot 0 is NOT removed. It stays and drains normally so that `mem_addr` remains stable while offered. `lk_hit` is still 1 and `num_reclaims` is unchanged.
- Simultaneous events in one cycle; all combinations are legal:
  - Drain of slot 0 plus reclaim of slot k>0: both entries are removed and the remaining slots compact by two.
  - Push plus drain when count = DEPTH: `wb_ready` is already 0, so no push occurs. The freed slot becomes visible through `wb_ready` on the next cycle.
  - Push and lookup with `wb_addr == lk_addr`:
    - `lk_hit` = 1 whether or not an entry exists.
    - The push is not stored, and `num_reclaims` increments.
    - An existing slot k>0 with that address is also removed; an existing slot 0 stays.
  - Push plus drain when count < DEPTH: the push lands in the slot freed by compaction, so ordering is preserved.
- Duplicates never exist in the buffer. The coalesce and reclaim rules guarantee this invariant.
- Counters are 32-bit unsigned and wrap modulo 2^32. Each increments by at most 1 per cycle.

## Timing
- Reset (asynchronous assert, deassert sampled on `clk`):
  - All slots are invalid.
  - `count` = 0, `mem_valid` = 0, `mem_addr` = 0, `wb_ready` = 1.
  - `lk_hit` = 0, because no valid slot can match.
  - All counters are 0.
  - Reset asserted mid-drain abandons the pending writeback with no handshake recorded.
- A push accepted at edge N gives `mem_valid` = 1 after edge N when the buffer was empty. Push-to-offer latency is one cycle.
- A drain handshake at edge N presents the next slot's address on `mem_addr` after edge N, giving back-to-back throughput of one writeback per cycle.
- `mem_addr` is stable while `mem_valid & !mem_ready`. `mem_valid` never drops without a handshake, except on reset.
- `lk_hit` is combinational from registered slots and `lk_addr`, with zero-cycle latency. Removal takes effect at the next edge.
- `count` and `wb_ready` reflect registered state after each edge.

## Test plan
- **Reset and fill:** reset, then push 0x100, 0x101, 0x102, 0x103 with `mem_ready` = 0.
  - `count` = 4, `wb_ready` = 0, `mem_addr` = 0x100 held stable.
  - A fifth push of 0x104 is ignored.
- **Ordered drain:** with the buffer from the first test, hold `mem_ready` = 1 for 4 cycles.
  - `mem_addr` sequence is 0x100, 0x101, 0x102, 0x103.
  - `num_writebacks` = 4, `count` = 0, `mem_valid` = 0 on the fifth cycle.
- **Reclaim:** buffer holds 0x10, 0x20, 0x30; `lk_addr` = 0x20 with `mem_ready` = 0.
  - `lk_hit` = 1 and `count` = 2, leaving slots 0x10, 0x30.
  - `lk_addr` = 0x10 gives `lk_hit` = 1 with `count` unchanged.
- **Coalesce:** push 0x55, then push 0x55 again.
  - `count` = 1, `num_coalesced` = 1.
- **Simultaneous events:** buffer holds 0xA, 0xB, 0xC. In one cycle: `mem_ready` = 1, `lk_addr` = 0xC, and push 0xD.
  - After the edge the buffer holds 0xB, 0xD.
  - `num_writebacks` = 1, `num_reclaims` = 1.
- **Reset mid-operation:** assert `rst_n` = 0 while `mem_valid` = 1 with 3 entries.
  - `mem_valid` drops immediately (asynchronous), `count` = 0, all counters = 0.
